int_ctrl: RTL and testbench

//  Interrupt controller for the MCU51 core. Synchronises five interrupt sources, applies the IE/IP enable
//  and priority masks, and arbitrates at instruction boundaries. It hands one vector to the CU, which

---
 rtl/int_ctrl.sv | 168 ++++++++++++++++
 tb/tb_int_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// MCU51 interrupt controller: pin synchronisers, IE/IP masking, two-level priority
// arbitration at instruction boundaries, and in-service nesting tracking retired by RETI.
module int_ctrl #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] VEC_BASE    = 16'h0003,
  parameter int          VEC_STRIDE  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        insn_end,
  input  logic        hold,
  input  logic [7:0]  ie,
  input  logic [4:0]  ip,
  input  logic        it0,
  input  logic        it1,
  input  logic        int0_n,
  input  logic        int1_n,
  input  logic        tf0,
  input  logic        tf1,
  input  logic        ri_ti,
  input  logic        int_ack,
  input  logic        reti,
  output logic        int_req,
  output logic [15:0] int_vec,
  output logic        ie0,
  output logic        ie1,
  output logic        clr_tf0,
  output logic        clr_tf1,
  output logic [1:0]  in_service
);

  // Handshake: int_req/int_vec form a valid that is held, unchanged, from the cycle
  // after the pick until the CU answers with a one-cycle int_ack (the ready/accept).
  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sync0, sync1;
  logic                   prev0, prev1;
  logic                   pin0, pin1, fall0, fall1;
  logic [4:0]             flags, cand, hi, lo;
  logic                   arb_ok, pick_hi, pick_lo, pick;
  logic [2:0]             pick_idx, idx_q;
  logic                   level_q;
  logic                   blocked;
  logic                   ack_ok, reti_ok;
  logic [1:0]             in_service_next;
  logic                   unused_ie;

  assign unused_ie = &{1'b0, ie[6:5]};

  function automatic logic [2:0] lowest_set(input logic [4:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Pin synchronisers preset high so reset never looks like a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0 <= '1;
      sync1 <= '1;
      prev0 <= 1'b1;
      prev1 <= 1'b1;
    end else begin
      sync0 <= {sync0[SYNC_STAGES-2:0], int0_n};
      sync1 <= {sync1[SYNC_STAGES-2:0], int1_n};
      prev0 <= pin0;
      prev1 <= pin1;
    end
  end

  assign pin0  = sync0[SYNC_STAGES-1];
  assign pin1  = sync1[SYNC_STAGES-1];
  assign fall0 = prev0 & ~pin0;
  assign fall1 = prev1 & ~pin1;

  assign flags   = {ri_ti, tf1, ie1, tf0, ie0};
  assign cand    = flags & ie[4:0] & {5{ie[7]}};
  assign hi      = cand & ip;
  assign lo      = cand & ~ip;
  assign arb_ok  = (state == IDLE) & insn_end & ~hold & ~blocked;
  assign pick_hi = arb_ok & (|hi) & ~in_service[1];
  assign pick_lo = arb_ok & ~pick_hi & (|lo) & (in_service == 2'b00);
  assign pick    = pick_hi | pick_lo;
  assign pick_idx = pick_hi ? lowest_set(hi) : lowest_set(lo);

  assign ack_ok  = (state == PEND) & int_ack;
  assign reti_ok = reti & (in_service != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick) state_next = PEND;
      PEND:    if (int_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    int_req = 1'b0;
    int_vec = 16'h0000;
    if (state == PEND) begin
      int_req = 1'b1;
      int_vec = VEC_BASE + 16'(VEC_STRIDE) * 16'(idx_q);
    end
  end

  // The pick is frozen here so the request stays stable while pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= 3'd0;
      level_q <= 1'b0;
    end else if (pick) begin
      idx_q   <= pick_idx;
      level_q <= pick_hi;
    end
  end

  // RETI retires against the pre-ack nesting, then the acked level is marked.
  always_comb begin
    in_service_next = in_service;
    if (reti_ok) begin
      if (in_service[1]) in_service_next[1] = 1'b0;
      else               in_service_next[0] = 1'b0;
    end
    if (ack_ok) in_service_next[level_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_service <= 2'b00;
      blocked    <= 1'b0;
      clr_tf0    <= 1'b0;
      clr_tf1    <= 1'b0;
    end else begin
      in_service <= in_service_next;
      if (reti_ok)       blocked <= 1'b1;
      else if (insn_end) blocked <= 1'b0;
      clr_tf0 <= ack_ok & (idx_q == 3'd1);
      clr_tf1 <= ack_ok & (idx_q == 3'd3);
    end
  end

  // A new falling edge beats an ack clear in the same cycle so it is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie0 <= 1'b0;
      ie1 <= 1'b0;
    end else begin
      if (!it0)                           ie0 <= ~pin0;
      else if (fall0)                     ie0 <= 1'b1;
      else if (ack_ok && idx_q == 3'd0)   ie0 <= 1'b0;
      if (!it1)                           ie1 <= ~pin1;
      else if (fall1)                     ie1 <= 1'b1;
      else if (ack_ok && idx_q == 3'd2)   ie1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: each task drives one scenario and checks hand-computed values.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        insn_end, hold, it0, it1, int0_n, int1_n;
  logic        tf0, tf1, ri_ti, int_ack, reti;
  logic [7:0]  ie;
  logic [4:0]  ip;
  logic        int_req, ie0, ie1, clr_tf0, clr_tf1;
  logic [15:0] int_vec;
  logic [1:0]  in_service;

  int checks   = 0;
  int failures = 0;

  int_ctrl dut (
    .clk(clk), .reset(reset), .insn_end(insn_end), .hold(hold), .ie(ie), .ip(ip),
    .it0(it0), .it1(it1), .int0_n(int0_n), .int1_n(int1_n), .tf0(tf0), .tf1(tf1),
    .ri_ti(ri_ti), .int_ack(int_ack), .reti(reti), .int_req(int_req), .int_vec(int_vec),
    .ie0(ie0), .ie1(ie1), .clr_tf0(clr_tf0), .clr_tf1(clr_tf1), .in_service(in_service)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    insn_end = 0; hold = 0; it0 = 0; it1 = 0; int0_n = 1; int1_n = 1;
    tf0 = 0; tf1 = 0; ri_ti = 0; int_ack = 0; reti = 0; ie = 8'h00; ip = 5'h00;
    tick(3);
    reset = 1'b0;
    tick(1);
  endtask

  // Driver tasks
  task automatic pulse_insn_end();
    insn_end = 1'b1; tick(1); insn_end = 1'b0;
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1; tick(1); int_ack = 1'b0;
  endtask

  task automatic pulse_reti();
    reti = 1'b1; tick(1); reti = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({int_req, int_vec, ie0, ie1, clr_tf0, clr_tf1, in_service} !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs got req=%b vec=%h ie0=%b ie1=%b clr=%b%b is=%b exp all 0",
               int_req, int_vec, ie0, ie1, clr_tf0, clr_tf1, in_service);
    end
  endtask

  task automatic test_edge_int0();
    do_reset();
    ie = 8'h81; it0 = 1'b1; int0_n = 1'b0;
    tick(2);
    checks++;
    if (ie0 !== 1'b0) begin failures++; $display("FAIL ie0_early got=%b exp=0", ie0); end
    tick(1);
    checks++;
    if (ie0 !== 1'b1) begin failures++; $display("FAIL ie0_latency got=%b exp=1", ie0); end
    pulse_insn_end();
    checks++;
    if (int_req !== 1'b1 || int_vec !== 16'h0003) begin
      failures++; $display("FAIL int0_vector got req=%b vec=%h exp req=1 vec=0003", int_req, int_vec);
    end
    pulse_ack();
    checks++;
    if (int_req !== 1'b0 || ie0 !== 1'b0 || in_service !== 2'b01) begin
      failures++;
      $display("FAIL int0_ack got req=%b ie0=%b is=%b exp req=0 ie0=0 is=01", int_req, ie0, in_service);
    end
  endtask

  task automatic test_low_priority_and_reti_block();
    do_reset();
    ie = 8'h93; tf0 = 1'b1; ri_ti = 1'b1;
    pulse_insn_end();
    checks++;
    if (int_req !== 1'b1 || int_vec !== 16'h000B) begin
      failures++; $display("FAIL tf0_vector got req=%b vec=%h exp req=1 vec=000b", int_req, int_vec);
    end
    pulse_ack();
    tf0 = 1'b0;
    checks++;
    if (clr_tf0 !== 1'b1 || clr_tf1 !== 1'b0 || in_service !== 2'b01 || int_req !== 1'b0) begin
      failures++;
      $display("FAIL tf0_ack got clr0=%b clr1=%b is=%b req=%b exp 1 0 01 0", clr_tf0, clr_tf1, in_service, int_req);
    end
    tick(1);
    checks++;
    if (clr_tf0 !== 1'b0) begin failures++; $display("FAIL clr_tf0_width got=%b exp=0", clr_tf0); end
    pulse_insn_end();
    checks++;
    if (int_req !== 1'b0) begin failures++; $display("FAIL lo_nested_blocked got=%b exp=0", int_req); end
    pulse_reti();
    checks++;
    if (in_service !== 2'b00) begin failures++; $display("FAIL reti_lo got=%b exp=00", in_service); end
    pulse_insn_end();
    checks++;
    if (int_req !== 1'b0) begin failures++; $display("FAIL post_reti_block got=%b exp=0", int_req); end
    pulse_insn_end();
    checks++;
    if (int_req !== 1'b1 || int_vec !== 16'h0023) begin
      failures++; $display("FAIL serial_vector got req=%b vec=%h exp req=1 vec=0023", int_req, int_vec);
    end
    pulse_ack();
    checks++;
    if (clr_tf0 !== 1'b0 || clr_tf1 !== 1'b0 || in_service !== 2'b01) begin
      failures++;
      $display("FAIL serial_ack got clr0=%b clr1=%b is=%b exp 0 0 01", clr_tf0, clr_tf1, in_service);
    end
  endtask

  task automatic test_preempt();
    do_reset();
    ie = 8'h8A; tf0 = 1'b1;
    pulse_insn_end();
    pulse_ack();
    tf0 = 1'b0;
    ip = 5'h08; tf1 = 1'b1;
    pulse_insn_end();
    checks++;
    if (int_req !== 1'b1 || int_vec !== 16'h001B) begin
      failures++; $display("FAIL tf1_hi_vector got req=%b vec=%h exp req=1 vec=001b", int_req, int_vec);
    end
    pulse_ack();
    tf1 = 1'b0;
    checks++;
    if (in_service !== 2'b11 || clr_tf1 !== 1'b1) begin
      failures++; $display("FAIL hi_ack got is=%b clr1=%b exp is=11 clr1=1", in_service, clr_tf1);
    end
    pulse_reti();
    checks++;
    if (in_service !== 2'b01) begin failures++; $display("FAIL reti_hi got=%b exp=01", in_service); end
  endtask

  task automatic test_reti_ack_overlap();
    do_reset();
    ie = 8'h8A; tf0 = 1'b1;
    pulse_insn_end();
    pulse_ack();
    tf0 = 1'b0; ip = 5'h08; tf1 = 1'b1;
    pulse_insn_end();
    int_ack = 1'b1; reti = 1'b1;
    tick(1);
    int_ack = 1'b0; reti = 1'b0; tf1 = 1'b0;
    checks++;
    if (in_service !== 2'b10) begin failures++; $display("FAIL reti_ack_overlap got=%b exp=10", in_service); end
  endtask

  task automatic test_reti_ignored();
    do_reset();
    ie = 8'h82; tf0 = 1'b1;
    pulse_reti();
    pulse_insn_end();
    checks++;
    if (int_req !== 1'b1 || int_vec !== 16'h000B || in_service !== 2'b00) begin
      failures++;
      $display("FAIL idle_reti_ignored got req=%b vec=%h is=%b exp req=1 vec=000b is=00", int_req, int_vec, in_service);
    end
  endtask

  task automatic test_level_hold();
    do_reset();
    ie = 8'h84; it1 = 1'b0; int1_n = 1'b0;
    tick(3);
    checks++;
    if (ie1 !== 1'b1) begin failures++; $display("FAIL ie1_level got=%b exp=1", ie1); end
    hold = 1'b1;
    pulse_insn_end();
    hold = 1'b0;
    checks++;
    if (int_req !== 1'b0) begin failures++; $display("FAIL hold_suppress got=%b exp=0", int_req); end
    pulse_insn_end();
    int1_n = 1'b1;
    tick(4);
    checks++;
    if (int_req !== 1'b1 || int_vec !== 16'h0013 || ie1 !== 1'b0) begin
      failures++;
      $display("FAIL pend_committed got req=%b vec=%h ie1=%b exp req=1 vec=0013 ie1=0", int_req, int_vec, ie1);
    end
    pulse_ack();
    checks++;
    if (int_req !== 1'b0 || in_service !== 2'b01) begin
      failures++; $display("FAIL level_ack got req=%b is=%b exp req=0 is=01", int_req, in_service);
    end
  endtask

  task automatic test_edge_set_wins();
    do_reset();
    ie = 8'h81; it0 = 1'b1; int0_n = 1'b0;
    tick(3);
    pulse_insn_end();
    int0_n = 1'b1;
    tick(3);
    int0_n = 1'b0;
    tick(2);
    pulse_ack();
    checks++;
    if (ie0 !== 1'b1 || in_service !== 2'b01 || int_req !== 1'b0) begin
      failures++;
      $display("FAIL edge_set_wins got ie0=%b is=%b req=%b exp ie0=1 is=01 req=0", ie0, in_service, int_req);
    end
    pulse_ack();
    checks++;
    if (ie0 !== 1'b1 || in_service !== 2'b01) begin
      failures++; $display("FAIL idle_ack_ignored got ie0=%b is=%b exp ie0=1 is=01", ie0, in_service);
    end
  endtask

  task automatic test_reset_in_pend();
    do_reset();
    ie = 8'h83; it0 = 1'b1; it1 = 1'b0; int0_n = 1'b0; int1_n = 1'b0;
    tick(3);
    pulse_insn_end();
    pulse_ack();
    ip = 5'h02; tf0 = 1'b1;
    pulse_insn_end();
    checks++;
    if (int_req !== 1'b1 || int_vec !== 16'h000B || ie1 !== 1'b1 || in_service !== 2'b01) begin
      failures++;
      $display("FAIL pend_setup got req=%b vec=%h ie1=%b is=%b exp 1 000b 1 01", int_req, int_vec, ie1, in_service);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (int_req !== 1'b0 || int_vec !== 16'h0000 || in_service !== 2'b00 || ie0 !== 1'b0 || ie1 !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got req=%b vec=%h is=%b ie0=%b ie1=%b exp all 0", int_req, int_vec, in_service, ie0, ie1);
    end
    do_reset();
  endtask

  // Scenario sequence and final report
  initial begin
    test_reset();
    test_edge_int0();
    test_low_priority_and_reti_block();
    test_preempt();
    test_reti_ack_overlap();
    test_reti_ignored();
    test_level_hold();
    test_edge_set_wins();
    test_reset_in_pend();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
